// File: rtl/lsu_axi_if.sv
// rtl/lsu_axi_if.sv - AXI-lite data-side bus bundle between the LSU and memory
interface lsu_axi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_axi.sv
// rtl/lsu_axi.sv - load/store unit driving an AXI-lite master port (optional LSU_MISALIGN_CHK_EN)
module lsu_axi #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prev_valid,
  output logic              this_ready,
  output logic              this_valid,
  input  logic              next_ready,
  input  logic              req,
  input  logic              wen,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] ld_data,
  output logic              resp_err,
  output logic              misalign,
  lsu_axi_if.master         axi
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [DATA_W-1:0]   st_data_q, st_data_d;
  logic                arvalid_q, arvalid_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;
  logic                resp_err_q, resp_err_d;
  logic                misalign_q, misalign_d;

  logic [LANE_W-1:0]   lane;
  logic [LANE_W+2:0]   shamt;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   size_mask;
  logic [DATA_W-1:0]   sign_top;
  logic                rd_sext;
  logic [DATA_W-1:0]   ld_ext;
  logic [STRB_W-1:0]   strb_base;
  logic                mis_in;

  assign lane  = addr_q[LANE_W-1:0];
  assign shamt = {lane, 3'b000};

  // Byte-lane alignment of read data and store data, plus size-dependent masks
  always_comb begin
    size_mask = '1;
    strb_base = '1;
    case (funct3_q[1:0])
      2'd0: begin size_mask = DATA_W'(8'hFF);         strb_base = STRB_W'(1);  end
      2'd1: begin size_mask = DATA_W'(16'hFFFF);      strb_base = STRB_W'(3);  end
      2'd2: begin size_mask = DATA_W'(32'hFFFF_FFFF); strb_base = STRB_W'(15); end
      default: begin size_mask = '1;                  strb_base = '1;          end
    endcase
    rd_shift = axi.rdata >> shamt;
    // top bit of the access: the sign bit of the loaded value
    sign_top = size_mask & ~(size_mask >> 1);
    rd_sext  = !funct3_q[2] && (|(rd_shift & sign_top));
    ld_ext   = (rd_shift & size_mask) | (rd_sext ? ~size_mask : '0);
  end

`ifdef LSU_MISALIGN_CHK_EN
  // Alignment check on the incoming op: low address bits must be zero for the access size
  always_comb begin
    mis_in = 1'b0;
    case (funct3[1:0])
      2'd0:    mis_in = 1'b0;
      2'd1:    mis_in = addr[0];
      2'd2:    mis_in = |addr[1:0];
      default: mis_in = |addr[2:0];
    endcase
  end
`else
  assign mis_in = 1'b0;
`endif

  // Next-state and next-output computation for the transaction FSM
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    st_data_d  = st_data_q;
    arvalid_d  = arvalid_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    ld_data_d  = ld_data_q;
    resp_err_d = resp_err_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (prev_valid) begin
          addr_d     = addr;
          funct3_d   = funct3;
          st_data_d  = st_data;
          ld_data_d  = '0;
          resp_err_d = 1'b0;
          misalign_d = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if ((wen || req) && mis_in) begin
            misalign_d = 1'b1;
            state_d    = DONE;
          end else if (wen) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else if (req) begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_ADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.rvalid) begin
          ld_data_d  = ld_ext;
          resp_err_d = (axi.rresp != 2'b00);
          state_d    = DONE;
        end
      end
      WR: begin
        // AW and W retire independently; move on once both have been accepted
        if (awvalid_q && axi.awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && axi.wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          resp_err_d = (axi.bresp != 2'b00);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (next_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any outstanding transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      st_data_q  <= '0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ld_data_q  <= '0;
      resp_err_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      st_data_q  <= st_data_d;
      arvalid_q  <= arvalid_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      ld_data_q  <= ld_data_d;
      resp_err_q <= resp_err_d;
      misalign_q <= misalign_d;
    end
  end

  assign this_ready  = (state_q == IDLE);
  assign this_valid  = (state_q == DONE);
  assign ld_data     = ld_data_q;
  assign resp_err    = resp_err_q;
  assign misalign    = misalign_q;

  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = (state_q == RD_DATA);
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = st_data_q << shamt;
  assign axi.wstrb   = strb_base << lane;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_lsu_axi.sv
// tb/tb_lsu_axi.sv - directed self-checking bench for lsu_axi (32- and 64-bit instances)
module tb_lsu_axi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        pv, nr, rq, we, tr, tv, re, ma;
  logic [2:0]  f3;
  logic [31:0] ad, sd, ld;

  logic        pv6, nr6, rq6, we6, tr6, tv6, re6, ma6;
  logic [2:0]  f36;
  logic [31:0] ad6;
  logic [63:0] sd6, ld6;

  lsu_axi_if #(.DATA_W(32), .ADDR_W(32)) a32 ();
  lsu_axi_if #(.DATA_W(64), .ADDR_W(32)) a64 ();

  lsu_axi #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .prev_valid(pv), .this_ready(tr), .this_valid(tv),
    .next_ready(nr), .req(rq), .wen(we), .funct3(f3), .addr(ad), .st_data(sd),
    .ld_data(ld), .resp_err(re), .misalign(ma), .axi(a32.master)
  );

  lsu_axi #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .prev_valid(pv6), .this_ready(tr6), .this_valid(tv6),
    .next_ready(nr6), .req(rq6), .wen(we6), .funct3(f36), .addr(ad6), .st_data(sd6),
    .ld_data(ld6), .resp_err(re6), .misalign(ma6), .axi(a64.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic w, input logic r, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
    pv = 1'b1; we = w; rq = r; f3 = f; ad = a; sd = d;
    tick();
    pv = 1'b0; we = 1'b0; rq = 1'b0;
  endtask

  task automatic issue64(input logic w, input logic r, input logic [2:0] f,
                         input logic [31:0] a, input logic [63:0] d);
    pv6 = 1'b1; we6 = w; rq6 = r; f36 = f; ad6 = a; sd6 = d;
    tick();
    pv6 = 1'b0; we6 = 1'b0; rq6 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    pv = 0; nr = 0; rq = 0; we = 0; f3 = 0; ad = 0; sd = 0;
    pv6 = 0; nr6 = 0; rq6 = 0; we6 = 0; f36 = 0; ad6 = 0; sd6 = 0;
    a32.arready = 0; a32.rdata = 0; a32.rresp = 0; a32.rvalid = 0;
    a32.awready = 0; a32.wready = 0; a32.bresp = 0; a32.bvalid = 0;
    a64.arready = 0; a64.rdata = 0; a64.rresp = 0; a64.rvalid = 0;
    a64.awready = 0; a64.wready = 0; a64.bresp = 0; a64.bvalid = 0;

    // reset state
    #12;
    chk("rst_this_ready", tr, 1);
    chk("rst_this_valid", tv, 0);
    chk("rst_arvalid", a32.arvalid, 0);
    chk("rst_awvalid", a32.awvalid, 0);
    chk("rst_wvalid", a32.wvalid, 0);
    chk("rst_rready", a32.rready, 0);
    chk("rst_bready", a32.bready, 0);
    chk("rst_ld_data", ld, 0);
    chk("rst_resp_err", re, 0);
    chk("rst_misalign", ma, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // LB from 0x8000_0003, zero-wait slave
    a32.arready = 1; a32.rvalid = 1; a32.rdata = 32'h80FF_1234; a32.rresp = 0;
    issue32(0, 1, 3'b000, 32'h8000_0003, 0);
    chk("lb_c1_arvalid", a32.arvalid, 1);
    chk("lb_c1_araddr", a32.araddr, 32'h8000_0003);
    chk("lb_c1_this_ready", tr, 0);
    chk("lb_c1_this_valid", tv, 0);
    tick();
    chk("lb_c2_rready", a32.rready, 1);
    chk("lb_c2_arvalid", a32.arvalid, 0);
    chk("lb_c2_this_valid", tv, 0);
    tick();
    chk("lb_c3_this_valid", tv, 1);
    chk("lb_c3_ld_data", ld, 32'hFFFF_FF80);
    chk("lb_c3_resp_err", re, 0);
    chk("lb_c3_rready", a32.rready, 0);
    nr = 1; tick(); nr = 0;
    chk("lb_this_ready_back", tr, 1);
    chk("lb_this_valid_drop", tv, 0);
    a32.arready = 0; a32.rvalid = 0;

    // SH 0xABCD to 0x102, awready three cycles after wready
    a32.wready = 1; a32.awready = 0; a32.bvalid = 0; a32.bresp = 0;
    issue32(1, 0, 3'b001, 32'h0000_0102, 32'h0000_ABCD);
    chk("sh1_c1_awvalid", a32.awvalid, 1);
    chk("sh1_c1_wvalid", a32.wvalid, 1);
    chk("sh1_wdata", a32.wdata, 32'hABCD_0000);
    chk("sh1_wstrb", a32.wstrb, 4'b1100);
    chk("sh1_awaddr", a32.awaddr, 32'h0000_0102);
    tick();
    chk("sh1_c2_wvalid", a32.wvalid, 0);
    chk("sh1_c2_awvalid", a32.awvalid, 1);
    tick();
    chk("sh1_c3_awvalid", a32.awvalid, 1);
    chk("sh1_c3_bready", a32.bready, 0);
    tick();
    a32.awready = 1;
    tick();
    a32.awready = 0;
    chk("sh1_c5_awvalid", a32.awvalid, 0);
    chk("sh1_c5_bready", a32.bready, 1);
    chk("sh1_c5_this_valid", tv, 0);
    a32.bvalid = 1;
    tick();
    a32.bvalid = 0;
    chk("sh1_c6_this_valid", tv, 1);
    chk("sh1_c6_bready", a32.bready, 0);
    chk("sh1_resp_err", re, 0);
    chk("sh1_ld_data", ld, 0);
    nr = 1; tick(); nr = 0;

    // same store, awready before wready
    a32.awready = 1; a32.wready = 0;
    issue32(1, 0, 3'b001, 32'h0000_0102, 32'h0000_ABCD);
    chk("sh2_c1_awvalid", a32.awvalid, 1);
    chk("sh2_c1_wvalid", a32.wvalid, 1);
    tick();
    chk("sh2_c2_awvalid", a32.awvalid, 0);
    chk("sh2_c2_wvalid", a32.wvalid, 1);
    chk("sh2_c2_bready", a32.bready, 0);
    a32.wready = 1;
    tick();
    a32.wready = 0; a32.awready = 0;
    chk("sh2_c3_wvalid", a32.wvalid, 0);
    chk("sh2_c3_bready", a32.bready, 1);
    a32.bvalid = 1;
    tick();
    a32.bvalid = 0;
    chk("sh2_c4_this_valid", tv, 1);
    chk("sh2_c4_bready", a32.bready, 0);
    nr = 1; tick(); nr = 0;

    // LHU with SLVERR, then downstream stall for four cycles
    a32.arready = 1; a32.rvalid = 1; a32.rdata = 32'h80FF_1234; a32.rresp = 2'b10;
    issue32(0, 1, 3'b101, 32'h0000_0006, 0);
    tick();
    tick();
    chk("lhu_this_valid", tv, 1);
    chk("lhu_resp_err", re, 1);
    chk("lhu_ld_data", ld, 32'h0000_80FF);
    a32.rdata = 32'hDEAD_BEEF; a32.rresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_this_valid", tv, 1);
      chk("stall_this_ready", tr, 0);
      chk("stall_ld_data", ld, 32'h0000_80FF);
      chk("stall_resp_err", re, 1);
      chk("stall_misalign", ma, 0);
      chk("stall_rready", a32.rready, 0);
    end
    nr = 1; tick(); nr = 0;
    a32.arready = 0; a32.rvalid = 0;
    chk("lhu_this_ready_back", tr, 1);

    // reset while arvalid waits for arready
    issue32(0, 1, 3'b010, 32'h0000_0020, 0);
    chk("rstmid_c1_arvalid", a32.arvalid, 1);
    tick();
    chk("rstmid_c2_arvalid", a32.arvalid, 1);
    #3;
    rst_n = 1'b0;
    #2;
    chk("rstmid_arvalid", a32.arvalid, 0);
    chk("rstmid_this_valid", tv, 0);
    chk("rstmid_this_ready", tr, 1);
    chk("rstmid_rready", a32.rready, 0);
    #2;
    rst_n = 1'b1;
    tick();
    issue32(0, 0, 3'b000, 32'h0, 0);
    chk("after_rst_nonmem_this_valid", tv, 1);
    chk("after_rst_nonmem_ld_data", ld, 0);
    chk("after_rst_nonmem_arvalid", a32.arvalid, 0);
    nr = 1; tick(); nr = 0;
    chk("after_rst_this_ready", tr, 1);

    // LW from 0x2
    a32.arready = 1; a32.rvalid = 1; a32.rdata = 32'h80FF_1234; a32.rresp = 0;
    issue32(0, 1, 3'b010, 32'h0000_0002, 0);
`ifdef LSU_MISALIGN_CHK_EN
    chk("mis_c1_arvalid", a32.arvalid, 0);
    chk("mis_c1_misalign", ma, 1);
    chk("mis_c1_this_valid", tv, 1);
    chk("mis_c1_ld_data", ld, 0);
    chk("mis_c1_resp_err", re, 0);
    nr = 1; tick(); nr = 0;
    chk("mis_after_arvalid", a32.arvalid, 0);
`else
    chk("lw2_c1_arvalid", a32.arvalid, 1);
    chk("lw2_c1_araddr", a32.araddr, 32'h0000_0002);
    chk("lw2_c1_misalign", ma, 0);
    tick();
    tick();
    chk("lw2_c3_this_valid", tv, 1);
    chk("lw2_c3_ld_data", ld, 32'h0000_80FF);
    chk("lw2_c3_misalign", ma, 0);
    nr = 1; tick(); nr = 0;
`endif
    a32.arready = 0; a32.rvalid = 0;

    // 64-bit bus: LD from 0x10, then SB to 0x17
    a64.arready = 1; a64.rvalid = 1; a64.rdata = 64'h0123_4567_89AB_CDEF; a64.rresp = 0;
    issue64(0, 1, 3'b011, 32'h0000_0010, 0);
    chk("ld64_c1_arvalid", a64.arvalid, 1);
    chk("ld64_c1_araddr", a64.araddr, 32'h0000_0010);
    tick();
    tick();
    chk("ld64_c3_this_valid", tv6, 1);
    chk("ld64_c3_ld_data", ld6, 64'h0123_4567_89AB_CDEF);
    nr6 = 1; tick(); nr6 = 0;
    a64.arready = 0; a64.rvalid = 0;
    a64.awready = 1; a64.wready = 1; a64.bvalid = 1; a64.bresp = 0;
    issue64(1, 0, 3'b000, 32'h0000_0017, 64'h0000_0000_0000_005A);
    chk("sb64_wstrb", a64.wstrb, 8'h80);
    chk("sb64_wdata", a64.wdata, 64'h5A00_0000_0000_0000);
    chk("sb64_awaddr", a64.awaddr, 32'h0000_0017);
    tick();
    chk("sb64_c2_bready", a64.bready, 1);
    chk("sb64_c2_awvalid", a64.awvalid, 0);
    tick();
    chk("sb64_c3_this_valid", tv6, 1);
    chk("sb64_c3_ld_data", ld6, 0);
    chk("sb64_c3_resp_err", re6, 0);
    nr6 = 1; tick(); nr6 = 0;
    chk("sb64_this_ready_back", tr6, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
